imem_fetch_ctrl: RTL
====================

# imem_fetch_ctrl

Instruction fetch controller sitting between the PC logic and the byte-addressed, big-endian 512-byte instruction memory. It owns the fetch PC, drives the memory address, captures the combinational 32-bit read data into a 2-entry fetch queue, and hands instructions to decode over a valid/ready handshake. It also handles branch/jump redirects with queue flush, and out-of-bounds/misaligned fetch faults.

## Interface
- `PC_RESET`, default 0: fetch PC value loaded at reset.
- `IMEM_BYTES`, default 512: instruction memory size in bytes. The last legal fetch address is `IMEM_BYTES-4`.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `fetch_en` input, 1 bit: permits new fetches. It does not block draining.
- `imem_addr` output, 64 bits: byte address to instruction memory. Combinational copy of the PC register.
- `imem_rdata` input, 32 bits: instruction returned by memory in the same cycle, MSB byte at `imem_addr`.
- `redirect_valid` input, 1 bit: redirect request from execute.
- `redirect_pc` input, 64 bits: redirect target.
- `out_valid` output, 1 bit: queue head is valid.
- `out_ready` input, 1 bit: decode accepts the head.
- `out_instr` output, 32 bits: instruction at the queue head.
- `out_pc` output, 64 bits: PC of the queue head.
- `fault` output, 1 bit: sticky fetch fault flag.

## Operation
- FSM has three states:
  - IDLE: no fetches.
  - RUN: fetching.
  - FAULT: fetching stopped after an illegal PC.
- Transitions:
  - IDLE→RUN when `fetch_en`=1.
  - RUN→IDLE when `fetch_en`=0.
  - RUN→FAULT on an illegal fetch.
  - FAULT→RUN, or FAULT→IDLE if `fetch_en`=0, only on `redirect_valid` with a legal target.
- A PC is legal when `pc[1:0]`==0 and `pc` <= `IMEM_BYTES-4`.
- Queue: 2 entries of {pc, instr}, FIFO order, with an occupancy count of 0..2.
  - Pop occurs when `out_valid` && `out_ready`.
- Enqueue condition: state RUN, no redirect, PC legal, and (count<2 or pop this cycle).
  - The entry is {pc, `imem_rdata`}.
  - The PC advances by 4, using 64-bit wrap arithmetic.
- Illegal PC in RUN: no enqueue, PC held, state→FAULT, `fault`←1. Entries already queued still drain normally.
- Redirect (highest priority, any state):
  - The queue is flushed (count←0), and any same-cycle pop is discarded.
  - No enqueue occurs that cycle, and `pc`←`redirect_pc`.
  - Illegal target: state→FAULT, `fault`←1.
  - Legal target: `fault`←0, and state→RUN if `fetch_en` else IDLE.
- Simultaneous pop and enqueue with count=2: legal. Count stays 2.
- Full queue with no pop: fetch stalls, PC and `imem_addr` held.

## Timing
- Reset values:
  - `pc`=`PC_RESET`, so `imem_addr`=`PC_RESET`.
  - count=0, `out_valid`=0, `out_instr`=0, `out_pc`=0, `fault`=0, state IDLE.
- Reset asserted mid-operation: all of the above take effect at that edge. Queued entries are lost.
- `fetch_en` rises at edge N: the state is RUN after edge N. The first enqueue happens at edge N+1, so `out_valid`=1 after N+1.
  - IDLE→RUN costs one cycle.
- Steady state with `out_ready`=1: one instruction per cycle, consecutive PCs differing by 4.
- Redirect at edge R:
  - `out_valid`=0 after R.
  - The target is enqueued at R+1 and presented after R+1. Redirect bubble is 1 cycle.
- `fault` is registered and changes one edge after the triggering condition.
- `out_*` are driven from registered queue storage only, with no combinational path from `imem_rdata`.

## Configuration
- Macro: `FETCH_BOUNDS_CHECK_EN`.
- Defined: the legality check and FAULT state behave as described above.
- Undefined:
  - Every PC is treated as legal, and the FAULT state is unreachable.
  - `fault` is tied to 0.
  - Out-of-range addresses still enqueue whatever `imem_rdata` returns.

## Test plan
- Reset with `PC_RESET`=0, `fetch_en`=1, `out_ready`=1 for 5 cycles → `out_pc` sequence 0,4,8,12 with `out_instr`=mem words. `out_valid` first high two edges after `fetch_en` rises.
- `out_ready`=0 for 4 cycles → count saturates at 2, `imem_addr` held at 8, no entry lost. Releasing `out_ready` yields PCs 0,4,8 in order.
- Redirect to 0x40 while the queue is full and `out_ready`=1 → queued entries discarded, `out_valid`=0 for 1 cycle, next `out_pc`=0x40.
- Sequential fetch reaching PC 508 (macro defined) → 508 is delivered, no enqueue occurs at PC 512, and `fault`=1 one edge later. A redirect to 0x10 clears `fault` and resumes with `out_pc`=0x10.
- Redirect to 0x42 → `fault`=1 and no enqueue. With the macro undefined, 0x42 is enqueued and `fault` stays 0.
- Pull `rst_n` low mid-stream with count=2 → after that edge `out_valid`=0, `imem_addr`=`PC_RESET`, `fault`=0, state IDLE.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Fetch controller: owns the PC and feeds a 2-entry {pc,instr} queue to decode. Start and redirect each cost 1 bubble, then 1 instr/cycle.
// A full queue with no pop stalls fetch and holds the PC. FETCH_BOUNDS_CHECK_EN enables the legal-PC check and the FAULT state.
module imem_fetch_ctrl #(
  parameter logic [63:0] PC_RESET   = 64'd0,
  parameter int          IMEM_BYTES = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] r_q_pc    [2];
  logic [31:0] r_q_instr [2];
  logic [1:0]  r_count;
  logic        w_pc_legal;
  logic        w_redir_legal;
  logic        w_pop;
  logic        w_enq;

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - 4);
  logic r_fault;

  assign w_pc_legal    = (r_pc[1:0] == 2'b00) && (r_pc <= LAST_PC);
  assign w_redir_legal = (redirect_pc[1:0] == 2'b00) && (redirect_pc <= LAST_PC);
  assign fault         = r_fault;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fault <= 1'b0;
    end else if (redirect_valid) begin
      r_fault <= !w_redir_legal;
    end else if (r_state == S_RUN && !w_pc_legal) begin
      r_fault <= 1'b1;
    end
  end
`else
  assign w_pc_legal    = 1'b1;
  assign w_redir_legal = 1'b1;
  assign fault         = 1'b0;
`endif

  assign imem_addr = r_pc;
  assign out_valid = (r_count != 2'd0);
  assign out_pc    = r_q_pc[0];
  assign out_instr = r_q_instr[0];
  assign w_pop     = out_valid && out_ready;
  assign w_enq     = (r_state == S_RUN) && !redirect_valid && w_pc_legal &&
                     ((r_count < 2'd2) || w_pop);

  always_comb begin
    w_state_nxt = r_state;
    if (redirect_valid) begin
      if (!w_redir_legal) w_state_nxt = S_FAULT;
      else                w_state_nxt = fetch_en ? S_RUN : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (fetch_en) w_state_nxt = S_RUN;
        S_RUN: begin
          if (!w_pc_legal)    w_state_nxt = S_FAULT;
          else if (!fetch_en) w_state_nxt = S_IDLE;
        end
        S_FAULT: w_state_nxt = S_FAULT;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RESET;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) r_pc <= redirect_pc;
      else if (w_enq)     r_pc <= r_pc + 64'd4;
    end
  end

  // Head is slot 0; on pop+enqueue the later write to slot 0 wins when only one entry was held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= 2'd0;
      r_q_pc[0]    <= 64'd0;
      r_q_pc[1]    <= 64'd0;
      r_q_instr[0] <= 32'd0;
      r_q_instr[1] <= 32'd0;
    end else if (redirect_valid) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_q_pc[0]    <= r_q_pc[1];
        r_q_instr[0] <= r_q_instr[1];
      end
      if (w_enq) begin
        if (r_count == 2'd0 || (r_count == 2'd1 && w_pop)) begin
          r_q_pc[0]    <= r_pc;
          r_q_instr[0] <= imem_rdata;
        end else begin
          r_q_pc[1]    <= r_pc;
          r_q_instr[1] <= imem_rdata;
        end
      end
      r_count <= r_count + 2'(w_enq) - 2'(w_pop);
    end
  end

endmodule
